sram_wait_model: RTL and testbench
==================================

Name: sram_wait_model

Overview:
- Parametrised, clocked SRAM memory model that the processor's SRAM port talks to in simulation. It extends the fixed-timing memory with configurable data/address width, depth and wait states.
- Each access is framed by an active-low chip-enable request. Completion is signalled by a one-cycle ready pulse, so the processor's memory stage stalls for exactly the configured latency.
- Sits on the SRAM bus between the processor top level and the bench, with a bidirectional data bus.

Parameters:
- DATA_W, 64, width of SRAM_DQ and of each stored word.
- ADDR_W, 16, width of SRAM_ADDR.
- DEPTH, 1024, number of stored words; power of two, at most 2**ADDR_W.
- WAIT, 4, wait-state cycles between request and completion; 0 allowed.
- INIT_ZERO, 1, 1 = memory array cleared to 0 on reset; 0 = contents preserved across reset.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- SRAM_CE_N  input  1  access request, active-low, sampled in IDLE.
- SRAM_WE_N  input  1  0 = write, 1 = read; sampled with the request.
- SRAM_ADDR  input  ADDR_W  word address; sampled with the request.
- SRAM_DQ  inout  DATA_W  write data in (sampled with the request) / read data out.
- SRAM_READY  output  1  one-cycle pulse when the access completes.
- access_cnt  output  32  count of completed accesses, for bench/debug.

Behaviour:
- Reset is synchronous and active-high. While rst=1 at a rising edge:
  - state <= IDLE, SRAM_READY=0, SRAM_DQ high-Z, access_cnt=0, wait counter=0.
  - If INIT_ZERO=1, every word is cleared to 0; otherwise the array is untouched.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If SRAM_CE_N=0, latch addr, we_n and DQ (write data) into internal registers.
  - If WAIT=0, go to DONE next cycle. Otherwise go to BUSY with counter=WAIT-1.
  - If SRAM_CE_N=1, stay in IDLE.
- BUSY:
  - If counter != 0, decrement and stay.
  - If counter == 0, go to DONE.
  - Input changes on CE_N, WE_N, ADDR and DQ are ignored.
- DONE (exactly one cycle):
  - SRAM_READY=1.
  - Read: SRAM_DQ driven with mem[addr_latched], combinationally from the array for this cycle.
  - Write: mem[addr_latched] <= wdata_latched at the rising edge leaving DONE.
  - access_cnt increments at that edge and wraps 2**32-1 -> 0.
  - Next state is always IDLE.
- Latency from the request edge to the ready cycle is WAIT+1 cycles. Back-to-back accesses have a minimum period of WAIT+2 cycles, because one IDLE cycle is required between accesses.
- The requester deasserts SRAM_CE_N in the cycle after SRAM_READY. If CE_N is still 0 in IDLE, a new access starts; this is legal and intended for streaming.
- SRAM_DQ is high-Z in all states except DONE-with-read. The model never drives DQ during a write.
- Address index is addr[log2(DEPTH)-1:0]. Upper bits are ignored, so aliasing is intended.
- Read-after-write to the same address returns the newly written data, because the write commits before the next IDLE.
- Reset in BUSY or DONE aborts the access:
  - a pending write is not committed;
  - SRAM_READY stays 0;
  - access_cnt is not incremented.
- Unknown/X on SRAM_CE_N in IDLE is treated as no request.

Test Plan:
- Reset: assert rst 2 cycles with INIT_ZERO=1, then read address 0x0010 -> READY pulse 5 cycles after request (WAIT=4), DQ=64'h0, access_cnt=1.
- Write-then-read: write 64'hDEADBEEF_CAFEF00D to 0x0005 then read 0x0005 -> read returns the same value, exactly one READY per access, access_cnt=2; DQ high-Z outside the read DONE cycle.
- WAIT=0 instance, streaming with CE_N held low: 4 reads -> READY every 2nd cycle, 4 pulses in 8 cycles.
- Aliasing (DEPTH=1024): write 64'h1 to 0x0403, read 0x0003 -> 64'h1; input changes on SRAM_ADDR during BUSY do not alter the target.
- Reset mid-write: request write 64'hFF to 0x0007, assert rst in BUSY cycle 2 -> no READY; with INIT_ZERO=0 a later read of 0x0007 returns the prior contents, and access_cnt=0.
- Counter wrap: force access_cnt to 32'hFFFFFFFF, complete one access -> access_cnt=0.

Source files
------------

// File: rtl/sram_wait_model.sv
// rtl/sram_wait_model.sv - wait-state SRAM simulation model with bidirectional data bus
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   SRAM_CE_N       access request (active-low), sampled in IDLE
//   SRAM_WE_N       0 = write, 1 = read, sampled with the request
//   SRAM_ADDR       word address, sampled with the request
//   SRAM_DQ         write data in (sampled with the request) / read data out in DONE
//   SRAM_READY      one-cycle completion pulse
//   access_cnt      number of completed accesses (wraps)
module sram_wait_model #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 1024,
  parameter int WAIT      = 4,
  parameter int INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_WE_N,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_READY,
  output logic [31:0]       access_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT > 1) ? $clog2(WAIT) : 1;
  // BUSY lasts WAIT cycles, so the counter is loaded with WAIT-1 and runs down to 0.
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_addr;
  logic              r_we_n;
  logic [DATA_W-1:0] r_wdata;
  logic [31:0]       r_access_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_done;
  logic              w_drive_dq;

  // Address bits above the index are ignored on purpose: the array aliases.
  generate
    if (ADDR_W > IDX_W) begin : g_addr_alias
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^SRAM_ADDR[ADDR_W-1:IDX_W];
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. An X on SRAM_CE_N makes the if-condition non-true,
  // so it is treated as no request.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!SRAM_CE_N) begin
          w_next_state = (WAIT == 0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_done     = 1'b0;
    w_drive_dq = 1'b0;
    SRAM_READY = 1'b0;
    if (r_state == S_DONE) begin
      w_done     = 1'b1;
      SRAM_READY = 1'b1;
      w_drive_dq = r_we_n;
    end
  end

  // Request capture, wait counter and completion counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_access_cnt <= '0;
      r_addr       <= '0;
      r_we_n       <= 1'b1;
      r_wdata      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!SRAM_CE_N) begin
            r_addr  <= SRAM_ADDR[IDX_W-1:0];
            r_we_n  <= SRAM_WE_N;
            r_wdata <= SRAM_DQ;
            r_cnt   <= CNT_LOAD;
          end
        end
        S_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_access_cnt <= r_access_cnt + 32'd1;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Storage array. Reset takes priority, so a write pending in DONE is dropped
  // when reset arrives on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (INIT_ZERO != 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_mem[i] <= '0;
        end
      end
    end else if (w_done && !r_we_n) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign SRAM_DQ    = w_drive_dq ? r_mem[r_addr] : {DATA_W{1'bz}};
  assign access_cnt = r_access_cnt;

endmodule

// File: tb/tb_sram_wait_model.sv
// tb/tb_sram_wait_model.sv - self-checking bench for sram_wait_model
module tb_sram_wait_model;

  localparam int DW    = 64;
  localparam int AW    = 16;
  localparam int DEPTH = 1024;
  localparam int W0    = 4;
  localparam int W1    = 0;
  localparam int W2    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst    [3];
  logic          ce_n   [3];
  logic          we_n   [3];
  logic [AW-1:0] addr   [3];
  logic [DW-1:0] dq_drv [3];
  logic          dq_en  [3];

  wire  [DW-1:0] dq0, dq1, dq2;
  logic          ready0, ready1, ready2;
  logic [31:0]   cnt0, cnt1, cnt2;

  assign dq0 = dq_en[0] ? dq_drv[0] : {DW{1'bz}};
  assign dq1 = dq_en[1] ? dq_drv[1] : {DW{1'bz}};
  assign dq2 = dq_en[2] ? dq_drv[2] : {DW{1'bz}};

  sram_wait_model #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT(W0), .INIT_ZERO(1)) u_dut0 (
    .clk(clk), .rst(rst[0]), .SRAM_CE_N(ce_n[0]), .SRAM_WE_N(we_n[0]), .SRAM_ADDR(addr[0]),
    .SRAM_DQ(dq0), .SRAM_READY(ready0), .access_cnt(cnt0));

  sram_wait_model #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT(W1), .INIT_ZERO(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .SRAM_CE_N(ce_n[1]), .SRAM_WE_N(we_n[1]), .SRAM_ADDR(addr[1]),
    .SRAM_DQ(dq1), .SRAM_READY(ready1), .access_cnt(cnt1));

  sram_wait_model #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT(W2), .INIT_ZERO(0)) u_dut2 (
    .clk(clk), .rst(rst[2]), .SRAM_CE_N(ce_n[2]), .SRAM_WE_N(we_n[2]), .SRAM_ADDR(addr[2]),
    .SRAM_DQ(dq2), .SRAM_READY(ready2), .access_cnt(cnt2));

  int checks   = 0;
  int failures = 0;

  // Reference model: plain word array per instance plus a completed-access tally.
  logic [DW-1:0] model_mem [3][DEPTH];
  int unsigned   model_cnt [3];

  function automatic int wait_of(input int inst);
    case (inst)
      0:       return W0;
      1:       return W1;
      default: return W2;
    endcase
  endfunction

  function automatic logic [DW-1:0] get_dq(input int inst);
    case (inst)
      0:       return dq0;
      1:       return dq1;
      default: return dq2;
    endcase
  endfunction

  function automatic logic get_rdy(input int inst);
    case (inst)
      0:       return ready0;
      1:       return ready1;
      default: return ready2;
    endcase
  endfunction

  function automatic logic [31:0] get_cnt(input int inst);
    case (inst)
      0:       return cnt0;
      1:       return cnt1;
      default: return cnt2;
    endcase
  endfunction

  function automatic int midx(input logic [AW-1:0] a);
    return int'(a) % DEPTH;
  endfunction

  // Drives one request from a negedge and waits for READY (bounded). After the
  // request edge the other inputs are scrambled: they must be ignored.
  // Returns the observed latency in cycles (-1 on timeout), read data and
  // READY one cycle after the pulse. Leaves the bench on an IDLE negedge.
  task automatic access(input int inst, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                        output int lat, output logic rdy_after);
    lat       = -1;
    rd        = '0;
    rdy_after = 1'b0;
    ce_n[inst]   = 1'b0;
    we_n[inst]   = !wr;
    addr[inst]   = a;
    dq_drv[inst] = wd;
    dq_en[inst]  = wr;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (get_rdy(inst)) begin
        lat = n;
        rd  = get_dq(inst);
        break;
      end
      ce_n[inst] = 1'b1;
      we_n[inst] = 1'($urandom);
      addr[inst] = AW'($urandom);
      if (wr) dq_drv[inst] = {$urandom, $urandom};
    end
    ce_n[inst]  = 1'b1;
    dq_en[inst] = 1'b0;
    @(negedge clk);
    rdy_after = get_rdy(inst);
    if (lat > 0) begin
      if (wr) model_mem[inst][midx(a)] = wd;
      model_cnt[inst] = model_cnt[inst] + 1;
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] rd;
    int            lat;
    logic          ra;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (get_rdy(i) !== 1'b0 || get_cnt(i) !== 32'd0) begin
        failures++;
        $display("FAIL reset_state inst=%0d ready=%b cnt=%0d required ready=0 cnt=0", i, get_rdy(i), get_cnt(i));
      end
    end
    access(0, 1'b1, 16'h0010, {$urandom | 32'h1, $urandom}, rd, lat, ra);
    rst[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    for (int k = 0; k < DEPTH; k++) model_mem[0][k] = '0;
    model_cnt[0] = 0;
    checks++;
    if (ready0 !== 1'b0 || cnt0 !== 32'd0) begin
      failures++;
      $display("FAIL reset_clear ready=%b cnt=%0d required ready=0 cnt=0", ready0, cnt0);
    end
    access(0, 1'b0, 16'h0010, '0, rd, lat, ra);
    checks++;
    if (lat !== W0 + 1) begin
      failures++;
      $display("FAIL reset_read_latency got=%0d required=%0d", lat, W0 + 1);
    end
    checks++;
    if (rd !== 64'h0) begin
      failures++;
      $display("FAIL reset_read_zero got=%h required=0", rd);
    end
    checks++;
    if (cnt0 !== 32'd1) begin
      failures++;
      $display("FAIL reset_cnt got=%0d required=1", cnt0);
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] rd;
    logic [DW-1:0] probe;
    int            lat;
    logic          ra;
    access(0, 1'b1, 16'h0005, 64'hDEADBEEF_CAFEF00D, rd, lat, ra);
    checks++;
    if (lat !== W0 + 1 || ra !== 1'b0) begin
      failures++;
      $display("FAIL wr_latency got=%0d ready_after=%b required=%0d,0", lat, ra, W0 + 1);
    end
    access(0, 1'b0, 16'h0005, '0, rd, lat, ra);
    checks++;
    if (rd !== 64'hDEADBEEF_CAFEF00D || lat !== W0 + 1 || ra !== 1'b0) begin
      failures++;
      $display("FAIL rd_after_wr got=%h lat=%0d ready_after=%b required=deadbeefcafef00d lat=%0d", rd, lat, ra, W0 + 1);
    end
    checks++;
    if (cnt0 !== model_cnt[0]) begin
      failures++;
      $display("FAIL wr_rd_cnt got=%0d required=%0d", cnt0, model_cnt[0]);
    end
    // Bus must be free in IDLE: the bench's own drive reads back unchanged.
    probe = {$urandom, $urandom};
    dq_drv[0] = probe;
    dq_en[0]  = 1'b1;
    #1;
    checks++;
    if (dq0 !== probe) begin
      failures++;
      $display("FAIL dq_free_idle got=%h required=%h", dq0, probe);
    end
    dq_en[0] = 1'b0;
    // Read again, probing the bus during BUSY.
    ce_n[0] = 1'b0;
    we_n[0] = 1'b1;
    addr[0] = 16'h0005;
    @(negedge clk);
    ce_n[0] = 1'b1;
    probe = ~probe;
    dq_drv[0] = probe;
    dq_en[0]  = 1'b1;
    #1;
    checks++;
    if (dq0 !== probe) begin
      failures++;
      $display("FAIL dq_free_busy got=%h required=%h", dq0, probe);
    end
    dq_en[0] = 1'b0;
    lat = -1;
    for (int n = 2; n <= 24; n++) begin
      @(negedge clk);
      if (ready0) begin
        lat = n;
        rd  = dq0;
        break;
      end
    end
    model_cnt[0] = model_cnt[0] + 1;
    checks++;
    if (lat !== W0 + 1 || rd !== 64'hDEADBEEF_CAFEF00D) begin
      failures++;
      $display("FAIL rd_probe_busy lat=%0d data=%h required lat=%0d data=deadbeefcafef00d", lat, rd, W0 + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_alias();
    logic [DW-1:0] rd;
    int            lat;
    logic          ra;
    access(0, 1'b1, 16'h0403, 64'h1, rd, lat, ra);
    access(0, 1'b0, 16'h0003, '0, rd, lat, ra);
    checks++;
    if (rd !== 64'h1) begin
      failures++;
      $display("FAIL alias_read got=%h required=1", rd);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] rd;
    logic [DW-1:0] wd;
    logic [AW-1:0] a;
    logic [DW-1:0] exp;
    int            lat;
    logic          ra;
    bit            wr;
    for (int it = 0; it < 40; it++) begin
      a        = '0;
      a[2:0]   = 3'($urandom_range(0, 7));
      a[15:10] = 6'($urandom);
      wr       = 1'($urandom);
      wd       = {$urandom, $urandom};
      exp      = model_mem[0][midx(a)];
      access(0, wr, a, wd, rd, lat, ra);
      checks++;
      if (lat !== W0 + 1 || ra !== 1'b0) begin
        failures++;
        $display("FAIL rand_timing it=%0d lat=%0d ready_after=%b required=%0d,0", it, lat, ra, W0 + 1);
      end
      if (!wr) begin
        checks++;
        if (rd !== exp) begin
          failures++;
          $display("FAIL rand_read it=%0d addr=%h got=%h required=%h", it, a, rd, exp);
        end
      end
    end
    checks++;
    if (cnt0 !== model_cnt[0]) begin
      failures++;
      $display("FAIL rand_cnt got=%0d required=%0d", cnt0, model_cnt[0]);
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] rd;
    logic [DW-1:0] pat;
    int            lat;
    logic          ra;
    int            pulses;
    pat = {$urandom, $urandom};
    access(1, 1'b1, 16'h0020, pat, rd, lat, ra);
    checks++;
    if (lat !== W1 + 1) begin
      failures++;
      $display("FAIL stream_wr_latency got=%0d required=%0d", lat, W1 + 1);
    end
    pulses   = 0;
    ce_n[1]  = 1'b0;
    we_n[1]  = 1'b1;
    addr[1]  = 16'h0020;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 8) ce_n[1] = 1'b1;
      if (ready1) begin
        pulses++;
        checks++;
        if ((n % 2) != 1 || dq1 !== pat) begin
          failures++;
          $display("FAIL stream_pulse cycle=%0d data=%h required odd cycle data=%h", n, dq1, pat);
        end
      end
    end
    model_cnt[1] = model_cnt[1] + 4;
    checks++;
    if (pulses !== 4) begin
      failures++;
      $display("FAIL stream_count got=%0d required=4", pulses);
    end
    @(negedge clk);
    checks++;
    if (cnt1 !== model_cnt[1]) begin
      failures++;
      $display("FAIL stream_cnt got=%0d required=%0d", cnt1, model_cnt[1]);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [DW-1:0] rd;
    logic [DW-1:0] prior;
    int            lat;
    logic          ra;
    int            seen;
    prior = {$urandom, $urandom | 32'h100};
    access(2, 1'b1, 16'h0007, prior, rd, lat, ra);
    ce_n[2]   = 1'b0;
    we_n[2]   = 1'b0;
    addr[2]   = 16'h0007;
    dq_drv[2] = 64'hFF;
    dq_en[2]  = 1'b1;
    @(negedge clk);
    ce_n[2]  = 1'b1;
    dq_en[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    model_cnt[2] = 0;
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ready2) seen++;
    end
    checks++;
    if (seen !== 0 || cnt2 !== 32'd0) begin
      failures++;
      $display("FAIL abort_write ready_pulses=%0d cnt=%0d required 0,0", seen, cnt2);
    end
    access(2, 1'b0, 16'h0007, '0, rd, lat, ra);
    checks++;
    if (rd !== prior || lat !== W2 + 1) begin
      failures++;
      $display("FAIL abort_preserve got=%h lat=%0d required=%h lat=%0d", rd, lat, prior, W2 + 1);
    end
    checks++;
    if (cnt2 !== model_cnt[2]) begin
      failures++;
      $display("FAIL abort_cnt got=%0d required=%0d", cnt2, model_cnt[2]);
    end
  endtask

  task automatic test_cnt_wrap();
    logic [DW-1:0] rd;
    int            lat;
    logic          ra;
    force u_dut0.r_access_cnt = 32'hFFFF_FFFF;
    #1;
    release u_dut0.r_access_cnt;
    model_cnt[0] = 32'hFFFF_FFFF;
    access(0, 1'b0, 16'h0001, '0, rd, lat, ra);
    checks++;
    if (cnt0 !== 32'(model_cnt[0]) || lat !== W0 + 1) begin
      failures++;
      $display("FAIL cnt_wrap got=%h lat=%0d required=%h lat=%0d", cnt0, lat, 32'(model_cnt[0]), W0 + 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i]    = 1'b1;
      ce_n[i]   = 1'b1;
      we_n[i]   = 1'b1;
      addr[i]   = '0;
      dq_drv[i] = '0;
      dq_en[i]  = 1'b0;
      model_cnt[i] = 0;
      for (int k = 0; k < DEPTH; k++) model_mem[i][k] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    test_reset();
    test_write_read();
    test_alias();
    test_random();
    test_stream();
    test_reset_mid_write();
    test_cnt_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
